bbox_drawer: RTL
================

# bbox_drawer

Writes a solid-colour rectangle outline into the 24-bit bottom-up BMP byte memory, using the same addressing that the bounding-box scanner uses when reading it. It consumes the scanner's xMin/xMax/yMin/yMax result and issues byte writes until the box edges are painted, with a start/done handshake. It sits downstream of the scanner, on the write port of the image memory.

## Interface
- WIDTH, 100: image width in pixels.
- HEIGHT, 100: image height in pixels.
- COLOUR, 24'hFF0000: box colour as {R,G,B}.
- clk  in  1  clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- start  in  1  begin a draw; sampled only in IDLE or FINISHED.
- done  out  1  high while in FINISHED.
- xMin, xMax, yMin, yMax  in  16 each  box corners in pixels, latched on accepted start.
- addr  out  32  byte address of the current write.
- wrdata  out  16  byte to write, zero-extended in [7:0].
- wren  out  1  write request.
- wrready  in  1  memory accepts the write this cycle. A write completes on a clock edge where wren && wrready.

## Operation
- Address: addr = (HEIGHT-1-y)*WIDTH*3 + x*3 + ch. ch 0 = B, 1 = G, 2 = R, so wrdata = COLOUR[7:0], [15:8], [23:16] respectively. No row padding is applied.
- Clamping on latch: values above WIDTH-1 are clamped to WIDTH-1, and values above HEIGHT-1 are clamped to HEIGHT-1.
- Empty box: if xMin > xMax or yMin > yMax after clamping, nothing is written. This covers the scanner's "nothing found" result of xMin=WIDTH-1, xMax=0.
- States:
  - IDLE: on start, latch the corners and go to TOP, or to FINISHED if the box is empty.
  - TOP: writes y=yMin, x=xMin..xMax.
  - BOTTOM: writes y=yMax, x=xMin..xMax. Skipped if yMax==yMin.
  - LEFT: writes x=xMin, y=yMin+1..yMax-1. Skipped if yMax-yMin<2.
  - RIGHT: writes x=xMax over the same y range. Skipped if xMax==xMin or yMax-yMin<2.
  - FINISHED: on start, re-latch the corners and restart.
- Each corner pixel is written exactly once.
- Within a pixel the write order is ch 0,1,2. Pixels are written in increasing x, or increasing y for the side columns.
- Counters and state advance only when a write completes. When wrready is low, addr, wrdata and wren hold.
- start is ignored in the draw states.
- Counter width is 16 bits. The address product is computed in 32 bits, so there is no overflow for WIDTH*HEIGHT*3 < 2^32.

## Timing
- Reset values: state IDLE, done=0, wren=0, addr=0, wrdata=0, latched corners 0. Reset asserted mid-draw drops wren immediately, with no partial-pixel completion.
- Cycle timing, with start seen at edge 0:
  - wren is high in the cycle after edge 0.
  - With wrready held high, one byte completes per edge, on edges 1..N.
  - After edge N the block is in FINISHED: done=1 and wren=0.
- Empty box: done=1 after edge 0, and wren never rises.
- Outline byte count: N = 3*(2*(xMax-xMin+1) + 2*(yMax-yMin-1)) for a box with height ≥2 and width ≥2.
- start held high in FINISHED restarts on every accepted edge. done drops in the cycle after the restart edge.
- wren is driven from registered state. addr and wrdata may be combinational from registers.

## Configuration
- BBOX_DRAW_FILL_EN defined: TOP/BOTTOM/LEFT/RIGHT are replaced by a single FILL state that rasters y=yMin..yMax, x=xMin..xMax. N = 3*(xMax-xMin+1)*(yMax-yMin+1).
- BBOX_DRAW_FILL_EN undefined: outline behaviour as above.

## Structure
- Package bbox_pkg holds:
  - the state enum (IDLE, TOP, BOTTOM, LEFT, RIGHT, FILL, FINISHED);
  - the channel constants CH_B=0, CH_G=1, CH_R=2;
  - the ADDR_W=32 and COORD_W=16 localparams.
- Sub-module bmp_addr_calc: combinational mapping of (x, y, ch) to addr, parameterised by WIDTH/HEIGHT. The scanner can reuse it.

## Test plan
- Box (10,20)-(12,22), wrready=1 → 24 writes. The first three are addr 23730/23731/23732 with data 0x00/0x00/0xFF. done rises after edge 24.
- Scanner's empty result (xMin=99, xMax=0, yMin=99, yMax=0) → no wren. done=1 one cycle after start.
- Single pixel (0,0)-(0,0) → exactly 3 writes at addr 29700..29702, then done.
- Box (5,5)-(8,9) with wrready toggling 1,0,1,0 → the same 42-byte sequence as with wrready=1, with addr/wrdata stable during stalls.
- xMax=150, yMax=120 → writes are clamped to x≤99 and y≤99, and no addr exceeds 29999.
- Reset asserted at the 7th write of a draw → wren=0 and done=0 asynchronously. A new start after reset draws the full box.

Source files
------------

// File: rtl/bbox_pkg.sv
// Shared types and constants for the bounding-box drawer and BMP address mapping.
package bbox_pkg;

    localparam int ADDR_W  = 32;
    localparam int COORD_W = 16;

    localparam logic [1:0] CH_B = 2'd0;
    localparam logic [1:0] CH_G = 2'd1;
    localparam logic [1:0] CH_R = 2'd2;

    typedef enum logic [2:0] {
        IDLE,
        TOP,
        BOTTOM,
        LEFT,
        RIGHT,
        FILL,
        FINISHED
    } state_t;

    function automatic logic [COORD_W-1:0] clamp_coord(input logic [COORD_W-1:0] v,
                                                       input logic [COORD_W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/bbox_drawer_if.sv
// Start/done handshake, box corners and image-memory write port of the drawer.
interface bbox_drawer_if;
    import bbox_pkg::*;

    logic               start;
    logic               done;
    logic [COORD_W-1:0] xMin;
    logic [COORD_W-1:0] xMax;
    logic [COORD_W-1:0] yMin;
    logic [COORD_W-1:0] yMax;
    logic [ADDR_W-1:0]  addr;
    logic [15:0]        wrdata;
    logic               wren;
    logic               wrready;

    modport slave (
        input  start, xMin, xMax, yMin, yMax, wrready,
        output done, addr, wrdata, wren
    );

    modport master (
        output start, xMin, xMax, yMin, yMax, wrready,
        input  done, addr, wrdata, wren
    );

endinterface

// File: rtl/bmp_addr_calc.sv
// Maps (x, y, channel) to a byte address in a 24-bit bottom-up BMP without row padding.
module bmp_addr_calc
    import bbox_pkg::*;
#(
    parameter int WIDTH  = 100,
    parameter int HEIGHT = 100
) (
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    input  logic [1:0]         ch_i,
    output logic [ADDR_W-1:0]  addr_o
);

    localparam logic [ADDR_W-1:0] ROW_BYTES = ADDR_W'(WIDTH * 3);
    localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(HEIGHT - 1);

    // Row 0 of the image lives at the end of memory, hence the flipped row index.
    always_comb begin
        addr_o = (LAST_ROW - ADDR_W'(y_i)) * ROW_BYTES
               + ADDR_W'(x_i) * ADDR_W'(3)
               + ADDR_W'(ch_i);
    end

endmodule

// File: rtl/bbox_drawer.sv
// Paints a solid-colour rectangle outline (or filled box with BBOX_DRAW_FILL_EN) into BMP memory.
module bbox_drawer
    import bbox_pkg::*;
#(
    parameter int          WIDTH  = 100,
    parameter int          HEIGHT = 100,
    parameter logic [23:0] COLOUR = 24'hFF0000
) (
    input logic          clk,
    input logic          rst,
    bbox_drawer_if.slave bus
);

    state_t             state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [COORD_W-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
    logic [COORD_W-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
    logic [1:0]         ch_q, ch_d;

    logic [COORD_W-1:0] xmin_c, xmax_c, ymin_c, ymax_c, y_span;
    logic               box_empty, drawing, wr_done;
    logic [7:0]         colour_byte;
    logic [ADDR_W-1:0]  calc_addr;

    assign xmin_c    = clamp_coord(bus.xMin, COORD_W'(WIDTH - 1));
    assign xmax_c    = clamp_coord(bus.xMax, COORD_W'(WIDTH - 1));
    assign ymin_c    = clamp_coord(bus.yMin, COORD_W'(HEIGHT - 1));
    assign ymax_c    = clamp_coord(bus.yMax, COORD_W'(HEIGHT - 1));
    assign box_empty = (xmin_c > xmax_c) || (ymin_c > ymax_c);
    assign y_span    = ymax_q - ymin_q;
    assign drawing   = state_q inside {TOP, BOTTOM, LEFT, RIGHT, FILL};
    assign wr_done   = drawing && bus.wrready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            ch_q    <= CH_B;
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymin_q  <= '0;
            ymax_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            ch_q    <= ch_d;
            xmin_q  <= xmin_d;
            xmax_q  <= xmax_d;
            ymin_q  <= ymin_d;
            ymax_q  <= ymax_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        ch_d    = ch_q;
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymin_d  = ymin_q;
        ymax_d  = ymax_q;
        case (state_q)
            IDLE, FINISHED: begin
                if (bus.start) begin
                    xmin_d = xmin_c;
                    xmax_d = xmax_c;
                    ymin_d = ymin_c;
                    ymax_d = ymax_c;
                    x_d    = xmin_c;
                    y_d    = ymin_c;
                    ch_d   = CH_B;
`ifdef BBOX_DRAW_FILL_EN
                    state_d = box_empty ? FINISHED : FILL;
`else
                    state_d = box_empty ? FINISHED : TOP;
`endif
                end
            end
            default: begin
                if (wr_done) begin
                    if (ch_q != CH_R) begin
                        ch_d = ch_q + 2'd1;
                    end else begin
                        ch_d = CH_B;
                        // Edge transitions skip segments that would repaint a corner pixel.
                        case (state_q)
                            TOP: begin
                                if (x_q != xmax_q) begin
                                    x_d = x_q + 16'd1;
                                end else if (ymax_q == ymin_q) begin
                                    state_d = FINISHED;
                                end else begin
                                    state_d = BOTTOM;
                                    x_d     = xmin_q;
                                    y_d     = ymax_q;
                                end
                            end
                            BOTTOM: begin
                                if (x_q != xmax_q) begin
                                    x_d = x_q + 16'd1;
                                end else if (y_span < 16'd2) begin
                                    state_d = FINISHED;
                                end else begin
                                    state_d = LEFT;
                                    x_d     = xmin_q;
                                    y_d     = ymin_q + 16'd1;
                                end
                            end
                            LEFT: begin
                                if (y_q != ymax_q - 16'd1) begin
                                    y_d = y_q + 16'd1;
                                end else if (xmax_q == xmin_q) begin
                                    state_d = FINISHED;
                                end else begin
                                    state_d = RIGHT;
                                    x_d     = xmax_q;
                                    y_d     = ymin_q + 16'd1;
                                end
                            end
                            RIGHT: begin
                                if (y_q != ymax_q - 16'd1) y_d = y_q + 16'd1;
                                else                       state_d = FINISHED;
                            end
                            FILL: begin
                                if (x_q != xmax_q) begin
                                    x_d = x_q + 16'd1;
                                end else if (y_q != ymax_q) begin
                                    x_d = xmin_q;
                                    y_d = y_q + 16'd1;
                                end else begin
                                    state_d = FINISHED;
                                end
                            end
                            default: state_d = IDLE;
                        endcase
                    end
                end
            end
        endcase
    end

    always_comb begin
        case (ch_q)
            CH_B:    colour_byte = COLOUR[7:0];
            CH_G:    colour_byte = COLOUR[15:8];
            default: colour_byte = COLOUR[23:16];
        endcase
    end

    bmp_addr_calc #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_addr (
        .x_i    (x_q),
        .y_i    (y_q),
        .ch_i   (ch_q),
        .addr_o (calc_addr)
    );

    assign bus.wren   = drawing;
    assign bus.done   = (state_q == FINISHED);
    assign bus.addr   = drawing ? calc_addr : '0;
    assign bus.wrdata = drawing ? {8'h00, colour_byte} : 16'h0000;

endmodule
